// File: rtl/uart_tx_queue_if.sv
// Bus-side word handshake into the UART transmit queue.
// Combinational wires only, so it adds no latency.
// Backpressure: in_ready low means the producer must hold in_data/in_valid.
interface uart_tx_queue_if #(
    parameter int DATA_WIDTH = 25
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    // Producer side (system bus)
    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    // Consumer side (the queue)
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Buffers bus words and hands them one at a time to the UART transmitter via data_input/data_en.
// Latency: push at edge t into an empty queue (UART idle) gives count=1 after t and data_en=1 after t+1.
// Backpressure: in_ready drops when FIFO_DEPTH words are stored; a transmitter that never acks is abandoned after ACK_TIMEOUT cycles.
module uart_tx_queue #(
    parameter int DATA_WIDTH  = 25,
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_queue_if.slave                in_bus,
    output logic [DATA_WIDTH-1:0]         data_input,
    output logic                          data_en,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ack_err,
    input  logic                          clr_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so ACK_TIMEOUT-1 always fits, including ACK_TIMEOUT=1.
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [TMR_W-1:0]        timer;
    logic [TMR_W-1:0]        timer_nxt;
    logic                    pop;
    logic                    push;
    logic                    set_err;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;

    // Full blocks pushes even when a pop happens in the same cycle, so in_ready
    // depends only on the registered count and never on the FSM.
    assign in_bus.in_ready = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign push            = in_bus.in_valid && in_bus.in_ready;
    assign data_en         = (state == LOAD);

    // FSM state and acknowledge timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Next-state logic: pop on IDLE->LOAD, wait for tx_busy in LOAD, wait for it to fall in DRAIN
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pop       = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if ((count != '0) && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (tx_busy) begin
                    timer_nxt = '0;
                    state_nxt = DRAIN;
                end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                    // Word is dropped, not retried; the sticky flag records it.
                    set_err   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Word storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_bus.in_data;
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH; count tracks occupancy separately
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head word is latched only on pop, so data_input moves only as data_en rises
    always_ff @(posedge clk) begin
        if (rst) begin
            data_input <= '0;
        end else if (pop) begin
            data_input <= mem[rd_ptr];
        end
    end

    // Sticky timeout flag; a new timeout wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_err <= 1'b0;
        end else if (set_err) begin
            ack_err <= 1'b1;
        end else if (clr_err) begin
            ack_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a small UART model and an in-order scoreboard.
// Words are queued as expected when accepted and popped when data_en rises.
// The UART model either acks after 3 cycles of data_en, never acks, or is held busy.
module tb_uart_tx_queue;

    localparam int DW    = 25;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_input;
    logic          data_en;
    logic          tx_busy;
    logic [3:0]    count;
    logic          ack_err;
    logic          clr_err = 1'b0;

    uart_tx_queue_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_queue #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (bus),
        .data_input(data_input),
        .data_en   (data_en),
        .tx_busy   (tx_busy),
        .count     (count),
        .ack_err   (ack_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sb_exp;

    // UART model controls
    bit ack_mode   = 1'b1;
    bit hold_busy  = 1'b0;
    bit model_busy = 1'b0;
    int en_run     = 0;
    int busy_left  = 0;

    // Monitor state
    int            run_len  = 0;
    int            last_run = 0;
    int            rise_cnt = 0;
    logic          prev_en  = 1'b0;
    logic [DW-1:0] held     = '0;

    assign tx_busy = hold_busy | model_busy;

    // UART model: raise tx_busy after data_en has been seen high for 3 cycles
    always @(negedge clk) begin
        if (rst) begin
            model_busy = 1'b0;
            en_run     = 0;
            busy_left  = 0;
        end else if (model_busy) begin
            if (busy_left == 0) model_busy = 1'b0;
            else                busy_left--;
        end else if (data_en === 1'b1) begin
            en_run++;
            if (ack_mode && en_run == 3) begin
                model_busy = 1'b1;
                busy_left  = 3;
                en_run     = 0;
            end
        end else begin
            en_run = 0;
        end
    end

    // Scoreboard monitor: order, stability of data_input and data_en run length
    always @(negedge clk) begin
        if (data_en === 1'b1 && prev_en !== 1'b1) begin
            rise_cnt++;
            run_len = 1;
            held    = data_input;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got=%h expected=none", data_input);
            end else begin
                sb_exp = exp_q.pop_front();
                if (data_input !== sb_exp) begin
                    errors++;
                    $display("FAIL word_order got=%h expected=%h", data_input, sb_exp);
                end
            end
        end else if (data_en === 1'b1) begin
            run_len++;
            checks++;
            if (data_input !== held) begin
                errors++;
                $display("FAIL data_stable got=%h expected=%h", data_input, held);
            end
            checks++;
            if (run_len > TMO) begin
                errors++;
                $display("FAIL en_run_limit got=%0d expected<=%0d", run_len, TMO);
            end
        end else if (prev_en === 1'b1) begin
            last_run = run_len;
        end
        prev_en = data_en;
    end

    task automatic push(input logic [DW-1:0] d, output bit acc);
        @(negedge clk);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        acc = bus.in_ready;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic idle_bus;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_en(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (data_en === level) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && data_en === 1'b0 && tx_busy == 1'b0 && count === 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b expected=0", bus.in_ready); end
        checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL rst_data_en got=%b expected=0", data_en); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d expected=0", count); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got=%b expected=0", ack_err); end
        checks++; if (data_input !== '0) begin errors++; $display("FAIL rst_data_input got=%h expected=0", data_input); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b expected=1", bus.in_ready); end
    endtask

    task automatic test_single;
        bit acc, ok;
        ack_mode = 1'b1;
        push(25'h15234A5, acc);
        idle_bus();
        #1;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL lat_count got=%0d expected=1", count); end
        checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL lat_en_early got=%b expected=0", data_en); end
        @(negedge clk);
        #1;
        checks++; if (data_en !== 1'b1) begin errors++; $display("FAIL lat_en got=%b expected=1", data_en); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL lat_count_pop got=%0d expected=0", count); end
        wait_en(1'b0, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_fall got=timeout expected=fall"); end
        checks++; if (last_run != 3) begin errors++; $display("FAIL single_en_len got=%0d expected=3", last_run); end
        wait_quiet(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_quiet got=busy expected=idle"); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL single_ack_err got=%b expected=0", ack_err); end
    endtask

    task automatic test_full;
        bit acc, all_acc, ok;
        all_acc = 1'b1;
        ack_mode = 1'b1;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(DW'(i), acc);
            all_acc &= acc;
        end
        push(25'h15234DD, acc);
        checks++; if (!all_acc) begin errors++; $display("FAIL full_accept got=refused expected=8_accepted"); end
        checks++; if (acc) begin errors++; $display("FAIL full_ninth got=accepted expected=refused"); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d expected=8", count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b expected=0", bus.in_ready); end
        idle_bus();
        #1;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count_hold got=%0d expected=8", count); end
        checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL busy_no_pop got=%b expected=0", data_en); end
        hold_busy = 1'b0;
        wait_quiet(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_drain got=%0d_left expected=0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        bit acc, ok;
        int tries;
        ack_mode = 1'b1;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(DW'(32'h100 + i), acc);
        push(DW'(32'h103), acc);
        hold_busy = 1'b0;
        idle_bus();
        #1;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL pushpop_count got=%0d expected=3", count); end
        checks++; if (data_en !== 1'b1) begin errors++; $display("FAIL pushpop_en got=%b expected=1", data_en); end
        for (int i = 4; i < 12; i++) begin
            tries = 0;
            do begin
                push(DW'(32'h100 + i), acc);
                tries++;
            end while (!acc && tries < 200);
            if (!acc) begin
                checks++; errors++;
                $display("FAIL wrap_push got=refused expected=accepted");
            end
        end
        idle_bus();
        wait_quiet(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_drain got=%0d_left expected=0", exp_q.size()); end
    endtask

    task automatic test_timeout;
        bit acc, ok;
        ack_mode = 1'b0;
        push(25'h1ABCDEF, acc);
        idle_bus();
        wait_en(1'b1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_rise got=timeout expected=rise"); end
        wait_en(1'b0, 40, ok);
        checks++; if (last_run != TMO) begin errors++; $display("FAIL tmo_en_len got=%0d expected=%0d", last_run, TMO); end
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL tmo_ack_err got=%b expected=1", ack_err); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL tmo_count got=%0d expected=0", count); end
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL clr_err got=%b expected=0", ack_err); end
    endtask

    task automatic test_reset_mid;
        bit acc, ok;
        int r0;
        ack_mode = 1'b0;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(DW'(32'h200 + i), acc);
        idle_bus();
        hold_busy = 1'b0;
        wait_en(1'b1, 20, ok);
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL mid_count got=%0d expected=4", count); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL mid_rst_en got=%b expected=0", data_en); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_rst_count got=%0d expected=0", count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b expected=0", bus.in_ready); end
        rst = 1'b0;
        exp_q.delete();
        r0 = rise_cnt;
        repeat (40) @(negedge clk);
        #1;
        checks++; if (rise_cnt != r0) begin errors++; $display("FAIL residual_tx got=%0d expected=0", rise_cnt - r0); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL residual_count got=%0d expected=0", count); end
    endtask

    task automatic test_set_wins;
        bit acc, ok;
        ack_mode = 1'b0;
        push(25'h0C0FFEE, acc);
        idle_bus();
        wait_en(1'b1, 20, ok);
        repeat (TMO - 1) @(negedge clk);
        checks++; if (data_en !== 1'b1) begin errors++; $display("FAIL setwin_en got=%b expected=1", data_en); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL set_wins got=%b expected=1", ack_err); end
        checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL setwin_en_low got=%b expected=0", data_en); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_single();
        test_full();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_set_wins();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Buffers DATA_WIDTH-bit words from the system-bus side and feeds them one at a time to the UART transmitter's data_input/data_en interface.
- Sits directly upstream of the uart transmitter.
- Decouples bus-side bursts from the slow serial line (one 25-bit frame takes about 27 bit-times at 9600 baud).
- Detects a transmitter that never accepts a word.

Parameters:
- DATA_WIDTH, 25: word width; matches the UART TX_DATA_WIDTH.
- FIFO_DEPTH, 8: number of buffered words; must be a power of two, at least 2.
- ACK_TIMEOUT, 16: cycles that data_en may stay high without tx_busy rising before the word is abandoned.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. One clock; reset is synchronous and active-high.
- in_data, input, DATA_WIDTH: word from the bus side.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: queue can accept a word this cycle.
- data_input, output, DATA_WIDTH: word presented to the UART transmitter.
- data_en, output, 1: transmit request to the UART.
- tx_busy, input, 1: UART transmitter busy.
- count, output, $clog2(FIFO_DEPTH)+1: number of words stored. Does not include the word in flight.
- ack_err, output, 1: sticky flag; a word was dropped on timeout.
- clr_err, input, 1: clears ack_err.

Behaviour:
- Reset values:
  - in_ready=0 while rst is high; 1 in the first cycle after reset.
  - data_en=0, data_input=0, count=0, ack_err=0.
  - FIFO pointers=0, FSM=IDLE, timer=0.
- Reset mid-operation:
  - All buffered words are discarded.
  - data_en is 0 from the reset edge.
  - A frame the UART has already started is not aborted by this block.
- Push: occurs on a clock edge where in_valid && in_ready. in_ready = !rst && (count < FIFO_DEPTH), combinational from count.
- Full case:
  - in_ready=0 even if a pop occurs in the same cycle.
  - in_valid while full is ignored with no side effects.
- Pop: occurs only on the IDLE->LOAD transition. Pop and push in the same cycle leave count unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. count is tracked separately.
- FSM:
  - IDLE: data_en=0. If count>0 and tx_busy==0, register the head word into data_input, pop it, go to LOAD.
  - LOAD: data_en=1, data_input held stable. timer increments each cycle.
    - If tx_busy==1: data_en=0 at the next edge, timer=0, go to DRAIN.
    - Else if timer==ACK_TIMEOUT-1: ack_err=1, data_en=0, timer=0, go to IDLE. The word is discarded, not retried.
  - DRAIN: data_en=0. When tx_busy==0, go to IDLE.
- Guarantees:
  - data_en is never high for more than ACK_TIMEOUT consecutive cycles.
  - data_input changes only in the cycle data_en rises.
- Latency: a word pushed into an empty queue at edge t (UART idle) gives count=1 after t and data_en=1 after t+1.
- Back-to-back words: the next data_en rises one cycle after tx_busy falls (DRAIN->IDLE->LOAD).
- ack_err:
  - Set has priority over clr_err in the same cycle.
  - Cleared only by clr_err or rst.
- tx_busy already high while in IDLE: no pop until it falls.

Test Plan:
1. Reset, push 25'h15234A5 with a UART model that raises tx_busy 2 cycles after data_en -> data_en high 3 cycles, data_input=25'h15234A5, count returns to 0, ack_err=0.
2. Push 8 words 25'h0000001..25'h0000008 back-to-back while tx_busy is held high -> in_ready=0 after the 8th push, count=8; a 9th push of 25'h15234DD is ignored. Release tx_busy -> all 8 words go out in order and the 9th never appears.
3. Simultaneous push and pop at count=3 -> count stays 3 and ordering is preserved across pointer wrap (push 12 words total).
4. UART model never raises tx_busy, push 25'h1ABCDEF -> data_en high exactly 16 cycles then low, ack_err=1, count=0. Assert clr_err one cycle -> ack_err=0.
5. Assert rst while in LOAD with 4 words queued -> next cycle data_en=0, count=0; after reset no residual words are transmitted.
6. Timeout coincident with clr_err -> ack_err=1 (set wins).
